// File: rtl/bp_me_burst_mem_responder.sv
// Burst CCE-MEM responder: accepts mem_cmd header + write beats, answers with mem_resp header + read beats.
// Optional byte-masked sub-dword writes under BP_ME_BURST_MEM_RESPONDER_WRMASK_EN.
//
// state      | meaning
// -----------+-------------------------------------------------
// e_idle     | waiting for a command header
// e_wr_data  | absorbing write data beats into storage
// e_delay    | response delay countdown
// e_resp_hdr | presenting the response header
// e_rd_data  | returning read data beats, critical word first
module bp_me_burst_mem_responder #(
   parameter int paddr_width_p     = 40,
   parameter int dword_width_p     = 64,
   parameter int lce_id_width_p    = 4,
   parameter int lce_assoc_p       = 8,
   parameter int cce_block_width_p = 512,
   parameter int mem_els_p         = 1024,
   parameter int resp_delay_p      = 0,
   localparam int lg_lce_assoc_lp  = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
   localparam int payload_width_lp = lce_id_width_p + lg_lce_assoc_lp + 3,
   localparam int cce_mem_msg_header_width_lp = payload_width_lp + 3 + paddr_width_p + 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,
   input  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
   input  logic                                   mem_cmd_header_v_i,
   output logic                                   mem_cmd_header_ready_and_o,
   input  logic [dword_width_p-1:0]               mem_cmd_data_i,
   input  logic                                   mem_cmd_data_v_i,
   output logic                                   mem_cmd_data_ready_and_o,
   output logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
   output logic                                   mem_resp_header_v_o,
   input  logic                                   mem_resp_header_ready_and_i,
   output logic [dword_width_p-1:0]               mem_resp_data_o,
   output logic                                   mem_resp_data_v_o,
   input  logic                                   mem_resp_data_ready_and_i
);

   // header layout, lsb first: msg_type[3:0], addr, size[2:0], payload
   localparam int lg_els_lp       = $clog2(mem_els_p);
   localparam int dw_idx_width_lp = paddr_width_p - 3;
   localparam int block_beats_lp  = cce_block_width_p / dword_width_p;
   localparam int cnt_width_lp    = $clog2((block_beats_lp > 16) ? block_beats_lp : 16) + 1;
   localparam int size_lsb_lp     = 4 + paddr_width_p;

   localparam logic [3:0] e_bedrock_mem_wr       = 4'd1;
   localparam logic [3:0] e_bedrock_mem_uc_wr    = 4'd3;
   localparam logic [2:0] e_bedrock_msg_size_8   = 3'd3;
   localparam logic [7:0] delay_init_lp = (resp_delay_p > 0) ? 8'(resp_delay_p - 1) : 8'd0;

   typedef enum logic [2:0] {
      e_idle,
      e_wr_data,
      e_delay,
      e_resp_hdr,
      e_rd_data
   } state_e;

   localparam state_e after_cmd_lp = (resp_delay_p == 0) ? e_resp_hdr : e_delay;

   function automatic logic is_wr(input logic [3:0] t);
      return (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
   endfunction

   state_e                                 state_r, state_n;
   logic [cce_mem_msg_header_width_lp-1:0] hdr_r, hdr_n;
   logic [cnt_width_lp-1:0]                beat_cnt_r, beat_cnt_n;
   logic [7:0]                             delay_cnt_r, delay_cnt_n;

   logic [3:0]                 hdr_type;
   logic [2:0]                 hdr_size;
   logic [cnt_width_lp-1:0]    beat_mask;
   logic                       last_beat;
   logic [dw_idx_width_lp-1:0] dw_idx, mask_ext, cnt_ext;
   logic [lg_els_lp-1:0]       mem_idx;
   logic                       mem_we;
   logic [dword_width_p-1:0]   wr_dword;
   logic                       resp_data_v;

   logic [dword_width_p-1:0] mem [mem_els_p];

   assign hdr_type  = hdr_r[3:0];
   assign hdr_size  = hdr_r[size_lsb_lp +: 3];
   assign beat_mask = (hdr_size <= e_bedrock_msg_size_8) ? '0
                    : cnt_width_lp'((32'd1 << (hdr_size - 3'd3)) - 32'd1);
   assign last_beat = (beat_cnt_r == beat_mask);

   // critical-word-first: low index bits advance and wrap inside the aligned block
   assign dw_idx   = hdr_r[7 +: dw_idx_width_lp];
   assign mask_ext = dw_idx_width_lp'(beat_mask);
   assign cnt_ext  = dw_idx_width_lp'(beat_cnt_r);
   assign mem_idx  = lg_els_lp'((dw_idx & ~mask_ext) | ((dw_idx + cnt_ext) & mask_ext));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= e_idle;
         hdr_r       <= '0;
         beat_cnt_r  <= '0;
         delay_cnt_r <= '0;
      end else begin
         state_r     <= state_n;
         hdr_r       <= hdr_n;
         beat_cnt_r  <= beat_cnt_n;
         delay_cnt_r <= delay_cnt_n;
      end
   end

   always_comb begin
      state_n                    = state_r;
      hdr_n                      = hdr_r;
      beat_cnt_n                 = beat_cnt_r;
      delay_cnt_n                = delay_cnt_r;
      mem_cmd_header_ready_and_o = 1'b0;
      mem_cmd_data_ready_and_o   = 1'b0;
      mem_resp_header_v_o        = 1'b0;
      resp_data_v                = 1'b0;
      mem_we                     = 1'b0;
      case (state_r)
         e_idle: begin
            mem_cmd_header_ready_and_o = 1'b1;
            if (mem_cmd_header_v_i) begin
               hdr_n       = mem_cmd_header_i;
               beat_cnt_n  = '0;
               delay_cnt_n = delay_init_lp;
               state_n     = is_wr(mem_cmd_header_i[3:0]) ? e_wr_data : after_cmd_lp;
            end
         end
         e_wr_data: begin
            mem_cmd_data_ready_and_o = 1'b1;
            if (mem_cmd_data_v_i) begin
               mem_we     = 1'b1;
               beat_cnt_n = beat_cnt_r + 1'b1;
               if (last_beat) begin
                  delay_cnt_n = delay_init_lp;
                  state_n     = after_cmd_lp;
               end
            end
         end
         e_delay: begin
            if (delay_cnt_r == 8'd0) state_n = e_resp_hdr;
            else                     delay_cnt_n = delay_cnt_r - 8'd1;
         end
         e_resp_hdr: begin
            mem_resp_header_v_o = 1'b1;
            if (mem_resp_header_ready_and_i) begin
               beat_cnt_n = '0;
               state_n    = is_wr(hdr_type) ? e_idle : e_rd_data;
            end
         end
         e_rd_data: begin
            resp_data_v = 1'b1;
            if (mem_resp_data_ready_and_i) begin
               beat_cnt_n = beat_cnt_r + 1'b1;
               if (last_beat) state_n = e_idle;
            end
         end
         default: state_n = e_idle;
      endcase
   end

`ifdef BP_ME_BURST_MEM_RESPONDER_WRMASK_EN
   logic [7:0]               byte_mask;
   logic [dword_width_p-1:0] bit_mask;

   // sub-dword writes touch only the addressed byte lanes; lanes past the dword end are dropped
   always_comb begin
      byte_mask = 8'hFF;
      if (hdr_size < e_bedrock_msg_size_8)
         byte_mask = 8'(((16'd1 << (4'd1 << hdr_size)) - 16'd1) << hdr_r[4 +: 3]);
      for (int b = 0; b < 8; b++) bit_mask[8*b +: 8] = {8{byte_mask[b]}};
      wr_dword = (mem[mem_idx] & ~bit_mask) | (mem_cmd_data_i & bit_mask);
   end
`else
   assign wr_dword = mem_cmd_data_i;
`endif

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_idx] <= wr_dword;
   end

   assign mem_resp_header_o = hdr_r;
   assign mem_resp_data_v_o = resp_data_v;
   assign mem_resp_data_o   = resp_data_v ? mem[mem_idx] : '0;

endmodule

// File: doc/bp_me_burst_mem_responder.md
Name: bp_me_burst_mem_responder

Overview:
- Memory-side responder for the BedRock burst CCE-MEM interface: the far end of the CCE's mem_cmd/mem_resp streams.
- Accepts a mem_cmd header plus write data beats, and services them from an internal dword-wide storage array.
- Returns a mem_resp header plus read data beats.
- Used in ME testbenches as the memory model behind a CCE, and as a scratchpad endpoint.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies paddr_width_p, dword_width_p (64), lce_id_width_p, lce_assoc_p, cce_block_width_p.
- mem_els_p, 1024, storage depth in dwords (power of two).
- resp_delay_p, 0, idle cycles from command completion to response header valid (0..255).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mem_cmd_header_i  in  cce_mem_msg_header_width_lp  command header (bp_bedrock_mem_header_s)
- mem_cmd_header_v_i  in  1  header valid
- mem_cmd_header_ready_and_o  out  1  header ready
- mem_cmd_data_i  in  dword_width_p  write data beat
- mem_cmd_data_v_i  in  1  data beat valid
- mem_cmd_data_ready_and_o  out  1  data beat ready
- mem_resp_header_o  out  cce_mem_msg_header_width_lp  response header
- mem_resp_header_v_o  out  1  response header valid
- mem_resp_header_ready_and_i  in  1  response header ready
- mem_resp_data_o  out  dword_width_p  read data beat
- mem_resp_data_v_o  out  1  read data valid
- mem_resp_data_ready_and_i  in  1  read data ready

Behaviour:
- Handshakes:
  - Clock is clk_i. Reset is reset_n_i: asynchronous, active-low.
  - All handshakes are ready&valid; a transfer occurs on a rising edge with both high.
  - Once valid is asserted, outputs hold valid and data stable until the transfer.
- Reset:
  - State returns to IDLE; all counters clear.
  - mem_cmd_header_ready_and_o=1, mem_cmd_data_ready_and_o=0, mem_resp_header_v_o=0, mem_resp_data_v_o=0, mem_resp_data_o=0.
  - Storage contents are not reset.
  - Reset asserted mid-transaction aborts it: no response is produced and partial write beats already stored remain.
- Beat count: beats = (size<=e_bedrock_msg_size_8) ? 1 : 2^(size-3).
- Beat addressing:
  - Beat i uses dword index ((addr>>3) & ~(beats-1)) | (((addr>>3)+i) & (beats-1)), taken mod mem_els_p.
  - This gives critical-word-first wrap within the aligned block.
- FSM:
  - IDLE: header_ready=1. On header transfer, latch the header and clear the beat counter.
    - Write types (e_bedrock_mem_wr, e_bedrock_mem_uc_wr) go to WR_DATA.
    - All other types go to DELAY.
  - WR_DATA: data_ready=1. Each beat transfer writes storage and increments the beat counter. After the last beat, go to DELAY.
  - DELAY: counts resp_delay_p cycles, then goes to RESP_HDR. With resp_delay_p=0, this state takes 0 cycles and the transition is direct.
  - RESP_HDR: header_v=1, header = latched command header unchanged. On transfer:
    - write types go to IDLE (no data beats);
    - read types go to RD_DATA with the beat counter cleared.
  - RD_DATA: data_v=1 with data = storage[beat index], read combinationally from the registered index. Each transfer increments the counter; after the last beat, go to IDLE.
- No overlap between transactions; the next header is not accepted until IDLE.
- Minimum read latency with resp_delay_p=0: header accepted in cycle N, response header valid in cycle N+1, first data beat valid the cycle after the response header transfers.
- Data beats presented in IDLE are not accepted (ready=0).
- Sub-dword reads return the full aligned dword.
- Other msg_types (e.g. e_bedrock_mem_pre, amo) are treated as reads.

Optional Feature:
- Macro: BP_ME_BURST_MEM_RESPONDER_WRMASK_EN.
- Defined: a write with size<e_bedrock_msg_size_8 updates only bytes addr[2:0] .. addr[2:0]+2^size-1, taking those bytes from the same lanes of mem_cmd_data_i. Remaining bytes are preserved.
- Undefined: every write beat overwrites the full dword.

Test Plan:
- Write, size 64B, addr 0x80, beats 0..7 = 0x1000+i → 8 data accepts, one resp header with addr 0x80, no resp data. Read of 64B @0x80 then returns 0x1000..0x1007 in order.
- Read 64B @0x90 after the previous write → beats return 0x1002,0x1003,…,0x1007,0x1000,0x1001 (wrap within the block).
- Read 8B @0x88 with mem_resp_data_ready_and_i held low for 5 cycles → data_v stays high, data stays 0x1001 throughout, one transfer, back to IDLE.
- resp_delay_p=3: read header accepted at cycle N → mem_resp_header_v_o first high at cycle N+4.
- With WRMASK_EN: after writing 0xFFFF_FFFF_FFFF_FFFF @0x100, write size 1B @0x103 with data lane3=0x5A → read @0x100 returns 0xFFFF_FFFF_5AFF_FFFF. Without the macro, the same read returns the full write dword.
- Drop reset_n_i low during WR_DATA after 3 of 8 beats → outputs reach reset values immediately. After release, a new read of the same block returns 3 new beats plus 5 old beats.
